// File: rtl/uart_frame_pkg.sv
// ---------------------------------------------------------------------------
// uart_frame_pkg
// Shared types and constants for the UART command-frame path.
//   frame_state_t : frame parser states (IDLE, LEN, PAYLOAD, CHECK)
//   ERR_*         : values reported on o_err_code alongside o_frame_error
// ---------------------------------------------------------------------------
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } frame_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

endpackage

// File: rtl/uart_frame_controller_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is presented on
// rd_data whenever empty is low; pop consumes it on the next clock edge.
// Ports:
//   i_clk    : clock
//   reset    : synchronous active-high reset (empties the FIFO)
//   push     : write wr_data this cycle (ignored when full unless popping)
//   wr_data  : data to write
//   pop      : consume the head entry (ignored when empty)
//   rd_data  : head entry (undefined contents while empty)
//   full     : DEPTH entries stored
//   empty    : no entries stored
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; the empty flag masks stale contents.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_controller.sv
// ---------------------------------------------------------------------------
// uart_frame_controller
// Turns raw UART byte strobes into checked command frames:
//   CMD, LEN, LEN payload bytes, CHK   with CHK = XOR(CMD, LEN, payload...)
// Payload bytes are buffered in a FIFO for a valid/ready consumer; the frame
// outcome is reported as a one-cycle done or error pulse.
// Ports:
//   i_clk, reset       : clock, synchronous active-high reset
//   i_enable           : global enable for frame reception
//   o_rx_enable        : receiver enable (i_enable gated by reset)
//   i_rx_data          : received byte, valid with i_rx_strobe
//   i_rx_strobe        : one pulse per received byte
//   i_rx_busy          : receiver is mid-byte (holds off a disable abort)
//   o_cmd, o_cmd_valid : command byte; valid from CMD capture to frame end
//   o_data, o_data_valid, i_data_ready : payload FIFO head and handshake
//   o_frame_done       : pulse, frame checksum matched
//   o_frame_error      : pulse, frame failed
//   o_err_code         : reason for the last error (checksum/timeout/overflow)
// TIMEOUT_TICKS must be >= 2; FIFO_DEPTH a power of two >= 2.
// ---------------------------------------------------------------------------
module uart_frame_controller
  import uart_frame_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 4096,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       i_enable,
  output logic       o_rx_enable,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_strobe,
  input  logic       i_rx_busy,
  output logic [7:0] o_cmd,
  output logic       o_cmd_valid,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  input  logic       i_data_ready,
  output logic       o_frame_done,
  output logic       o_frame_error,
  output logic [1:0] o_err_code
);

  localparam int             TW           = $clog2(TIMEOUT_TICKS);
  localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);

  frame_state_t  state;
  logic [7:0]    acc;
  logic [7:0]    remaining;
  logic [TW-1:0] idle_ticks;
  logic          overflow;

  logic          abort_now;
  logic          timeout_now;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rd_data;

  assign o_rx_enable = i_enable & ~reset;

  // Disabling mid-frame waits for the receiver to finish its current byte.
  assign abort_now   = (state != IDLE) & ~i_enable & ~i_rx_busy;
  // A strobe in the same cycle restarts the gap, so it always wins over timeout.
  assign timeout_now = (state != IDLE) & ~i_rx_strobe & (idle_ticks == TIMEOUT_LAST);

  assign fifo_pop  = ~fifo_empty & i_data_ready;
  assign fifo_push = i_rx_strobe & (state == PAYLOAD) & ~abort_now;

  // Masking the head with empty keeps o_data at zero out of reset.
  assign o_data       = fifo_empty ? 8'h00 : fifo_rd_data;
  assign o_data_valid = ~fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_payload_fifo (
    .i_clk   (i_clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (i_rx_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Frame parser. Abort takes priority over timeout, which takes priority
  // over byte handling. Every return to IDLE clears o_cmd_valid and the
  // overflow flag so the next frame starts clean.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state         <= IDLE;
      acc           <= 8'h00;
      remaining     <= 8'h00;
      idle_ticks    <= '0;
      overflow      <= 1'b0;
      o_cmd         <= 8'h00;
      o_cmd_valid   <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_error <= 1'b0;
      o_err_code    <= ERR_NONE;
    end else begin
      o_frame_done  <= 1'b0;
      o_frame_error <= 1'b0;

      if (state == IDLE || i_rx_strobe) begin
        idle_ticks <= '0;
      end else begin
        idle_ticks <= idle_ticks + TW'(1);
      end

      if (abort_now) begin
        state       <= IDLE;
        o_cmd_valid <= 1'b0;
        overflow    <= 1'b0;
      end else if (timeout_now) begin
        state         <= IDLE;
        o_cmd_valid   <= 1'b0;
        overflow      <= 1'b0;
        o_frame_error <= 1'b1;
        o_err_code    <= ERR_TIMEOUT;
      end else if (i_rx_strobe) begin
        case (state)
          IDLE: begin
            // A stray strobe while reception is disabled must not open a frame.
            if (i_enable) begin
              o_cmd       <= i_rx_data;
              o_cmd_valid <= 1'b1;
              acc         <= i_rx_data;
              overflow    <= 1'b0;
              state       <= LEN;
            end
          end
          LEN: begin
            remaining <= i_rx_data;
            acc       <= acc ^ i_rx_data;
            state     <= (i_rx_data == 8'h00) ? CHECK : PAYLOAD;
          end
          PAYLOAD: begin
            // Dropped bytes still count toward the length and checksum so the
            // frame boundary stays aligned with the sender.
            acc       <= acc ^ i_rx_data;
            remaining <= remaining - 8'd1;
            if (fifo_full && !fifo_pop) begin
              overflow <= 1'b1;
            end
            if (remaining == 8'd1) begin
              state <= CHECK;
            end
          end
          CHECK: begin
            if (overflow) begin
              o_frame_error <= 1'b1;
              o_err_code    <= ERR_OVERFLOW;
            end else if (i_rx_data != acc) begin
              o_frame_error <= 1'b1;
              o_err_code    <= ERR_CHECKSUM;
            end else begin
              o_frame_done <= 1'b1;
            end
            o_cmd_valid <= 1'b0;
            overflow    <= 1'b0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_controller.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_controller
// Drives byte strobes into uart_frame_controller and compares the frame
// outcome and delivered payload against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_uart_frame_controller;

  localparam int TIMEOUT_TICKS = 16;
  localparam int FIFO_DEPTH    = 4;

  logic       i_clk = 1'b0;
  logic       reset;
  logic       i_enable;
  logic       o_rx_enable;
  logic [7:0] i_rx_data;
  logic       i_rx_strobe;
  logic       i_rx_busy;
  logic [7:0] o_cmd;
  logic       o_cmd_valid;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       i_data_ready;
  logic       o_frame_done;
  logic       o_frame_error;
  logic [1:0] o_err_code;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] frame_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  int         err_cnt  = 0;
  bit         rand_ready = 0;

  uart_frame_controller #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .i_clk         (i_clk),
    .reset         (reset),
    .i_enable      (i_enable),
    .o_rx_enable   (o_rx_enable),
    .i_rx_data     (i_rx_data),
    .i_rx_strobe   (i_rx_strobe),
    .i_rx_busy     (i_rx_busy),
    .o_cmd         (o_cmd),
    .o_cmd_valid   (o_cmd_valid),
    .o_data        (o_data),
    .o_data_valid  (o_data_valid),
    .i_data_ready  (i_data_ready),
    .o_frame_done  (o_frame_done),
    .o_frame_error (o_frame_error),
    .o_err_code    (o_err_code)
  );

  always #5 i_clk = ~i_clk;

  // Consumer side: record every accepted byte and count outcome pulses.
  always @(negedge i_clk) begin
    if (!reset) begin
      if (o_data_valid && i_data_ready) got_q.push_back(o_data);
      if (o_frame_done) done_cnt++;
      if (o_frame_error) err_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  task automatic step();
    if (rand_ready) i_data_ready = 1'($urandom_range(0, 1));
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data   = b;
    i_rx_strobe = 1'b1;
    step();
    i_rx_strobe = 1'b0;
    i_rx_data   = 8'($urandom);
  endtask

  task automatic send_frame(input int max_gap, output logic d, output logic e,
                            output logic [1:0] c, output logic v);
    for (int i = 0; i < frame_q.size(); i++) begin
      int gap;
      gap = $urandom_range(0, max_gap);
      repeat (gap) step();
      send_byte(frame_q[i]);
    end
    d = o_frame_done;
    e = o_frame_error;
    c = o_err_code;
    v = o_cmd_valid;
  endtask

  // Reference model: checksum is the XOR of the first n frame bytes.
  function automatic logic [7:0] frame_xor(input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) x ^= frame_q[i];
    return x;
  endfunction

  // Reference model: payload bytes that a FIFO of FIFO_DEPTH with no consumer keeps.
  function automatic void model_payload(input int keep_limit);
    int len;
    len = int'(frame_q[1]);
    for (int i = 0; i < len && i < keep_limit; i++) exp_q.push_back(frame_q[2 + i]);
  endfunction

  function automatic bit queues_differ();
    if (got_q.size() != exp_q.size()) return 1'b1;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain();
    rand_ready   = 0;
    i_data_ready = 1'b1;
    for (int i = 0; i < 20 && o_data_valid; i++) step();
    tests_run++;
    if (o_data_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drain: o_data_valid got %b, expected 0", o_data_valid);
    end
  endtask

  task automatic begin_test();
    drain();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; i_enable = 1'b1; i_rx_strobe = 1'b0; i_rx_busy = 1'b0;
    i_data_ready = 1'b0; i_rx_data = 8'h00;
    step(); step();
    tests_run++;
    if (o_rx_enable !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_rx_enable: got %b, expected 0", o_rx_enable);
    end
    reset = 1'b0;
    step();
    tests_run++;
    if ({o_cmd, o_cmd_valid, o_data, o_data_valid, o_frame_done, o_frame_error, o_err_code} !== 21'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got cmd=%h cv=%b data=%h dv=%b done=%b err=%b code=%0d, expected all 0",
               o_cmd, o_cmd_valid, o_data, o_data_valid, o_frame_done, o_frame_error, o_err_code);
    end
    tests_run++;
    if (o_rx_enable !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL rx_enable_on: got %b, expected 1", o_rx_enable);
    end
  endtask

  task automatic test_good_frame();
    logic d, e, v; logic [1:0] c; int done0;
    begin_test();
    done0 = done_cnt;
    frame_q = {8'h10, 8'h02, 8'hAA, 8'h55};
    frame_q.push_back(frame_xor(4));
    model_payload(256);
    send_byte(frame_q[0]);
    tests_run++;
    if (o_cmd_valid !== 1'b1 || o_cmd !== 8'h10) begin
      tests_failed++; $display("[TB] FAIL good_cmd_capture: got cv=%b cmd=%h, expected 1/10", o_cmd_valid, o_cmd);
    end
    frame_q.pop_front();
    send_frame(0, d, e, c, v);
    tests_run++;
    if (d !== 1'b1 || e !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL good_done_pulse: got done=%b err=%b, expected 1/0", d, e);
    end
    tests_run++;
    if (v !== 1'b0 || o_cmd !== 8'h10) begin
      tests_failed++; $display("[TB] FAIL good_cmd_end: got cv=%b cmd=%h, expected 0/10", v, o_cmd);
    end
    step();
    tests_run++;
    if (o_frame_done !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL good_pulse_width: got done=%b, expected 0", o_frame_done);
    end
    drain();
    tests_run++;
    if (queues_differ() || done_cnt - done0 != 1) begin
      tests_failed++; $display("[TB] FAIL good_payload: got %0d bytes, %0d done, expected %0d bytes, 1 done",
                               got_q.size(), done_cnt - done0, exp_q.size());
    end
  endtask

  task automatic test_bad_checksum();
    logic d, e, v; logic [1:0] c; int done0;
    begin_test();
    done0 = done_cnt;
    frame_q = {8'h10, 8'h01, 8'h33, 8'h00};
    model_payload(256);
    send_frame(1, d, e, c, v);
    tests_run++;
    if (d !== 1'b0 || e !== 1'b1 || c !== 2'd1) begin
      tests_failed++; $display("[TB] FAIL bad_chk_outcome: got done=%b err=%b code=%0d, expected 0/1/1", d, e, c);
    end
    drain();
    tests_run++;
    if (done_cnt != done0 || queues_differ()) begin
      tests_failed++; $display("[TB] FAIL bad_chk_side: got %0d done pulses, %0d bytes, expected 0, %0d",
                               done_cnt - done0, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_zero_length();
    logic d, e, v; logic [1:0] c;
    begin_test();
    frame_q = {8'h20, 8'h00, 8'h20};
    send_frame(2, d, e, c, v);
    tests_run++;
    if (d !== 1'b1 || e !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL zero_len_done: got done=%b err=%b, expected 1/0", d, e);
    end
    step();
    tests_run++;
    if (o_data_valid !== 1'b0 || got_q.size() != 0) begin
      tests_failed++; $display("[TB] FAIL zero_len_nopush: got dv=%b bytes=%0d, expected 0/0", o_data_valid, got_q.size());
    end
  endtask

  task automatic test_random_frames();
    logic d, e, v; logic [1:0] c; bit good; int len;
    for (int n = 0; n < 20; n++) begin
      begin_test();
      len = $urandom_range(0, FIFO_DEPTH);
      frame_q = {};
      frame_q.push_back(8'($urandom));
      frame_q.push_back(8'(len));
      for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
      frame_q.push_back(frame_xor(len + 2));
      if ($urandom_range(0, 3) == 0) frame_q[len + 2] ^= 8'(1 << $urandom_range(0, 7));
      good = (frame_xor(len + 2) == frame_q[len + 2]);
      model_payload(256);
      rand_ready = 1;
      send_frame(3, d, e, c, v);
      tests_run++;
      if (d !== good || e !== !good || (!good && c !== 2'd1) || v !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rand_outcome[%0d]: got done=%b err=%b code=%0d cv=%b, expected done=%b err=%b code=1 cv=0",
                 n, d, e, c, v, good, !good);
      end
      drain();
      tests_run++;
      if (queues_differ()) begin
        tests_failed++; $display("[TB] FAIL rand_payload[%0d]: got %0d bytes, expected %0d (or content differs)",
                                 n, got_q.size(), exp_q.size());
      end
    end
  endtask

  task automatic test_timeout();
    logic d, e, v; logic [1:0] c; int hit;
    begin_test();
    send_byte(8'h10);
    hit = 0;
    for (int k = 1; k <= 40 && hit == 0; k++) begin
      step();
      if (o_frame_error) hit = k;
    end
    tests_run++;
    if (hit != TIMEOUT_TICKS || o_err_code !== 2'd2 || o_cmd_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL timeout_cmd: got after %0d cycles code=%0d cv=%b, expected %0d/2/0",
                               hit, o_err_code, o_cmd_valid, TIMEOUT_TICKS);
    end
    frame_q = {8'h30, 8'h00, 8'h30};
    send_frame(0, d, e, c, v);
    tests_run++;
    if (d !== 1'b1 || e !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL timeout_recover: got done=%b err=%b, expected 1/0", d, e);
    end
    // Timeout mid-payload: bytes already buffered stay deliverable.
    begin_test();
    i_data_ready = 1'b0;
    send_byte(8'h40); send_byte(8'h03); send_byte(8'h11);
    exp_q = {8'h11};
    hit = 0;
    for (int k = 1; k <= 40 && hit == 0; k++) begin
      step();
      if (o_frame_error) hit = k;
    end
    tests_run++;
    if (hit != TIMEOUT_TICKS || o_err_code !== 2'd2) begin
      tests_failed++; $display("[TB] FAIL timeout_payload: got after %0d cycles code=%0d, expected %0d/2",
                               hit, o_err_code, TIMEOUT_TICKS);
    end
    tests_run++;
    if (o_data_valid !== 1'b1 || o_data !== 8'h11) begin
      tests_failed++; $display("[TB] FAIL timeout_keep: got dv=%b data=%h, expected 1/11", o_data_valid, o_data);
    end
    drain();
    tests_run++;
    if (queues_differ()) begin
      tests_failed++; $display("[TB] FAIL timeout_drain: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_overflow();
    logic d, e, v; logic [1:0] c; int done0;
    begin_test();
    done0 = done_cnt;
    i_data_ready = 1'b0;
    frame_q = {8'h50, 8'h06};
    for (int i = 0; i < 6; i++) frame_q.push_back(8'($urandom));
    frame_q.push_back(frame_xor(8));
    model_payload(FIFO_DEPTH);
    send_frame(2, d, e, c, v);
    tests_run++;
    if (d !== 1'b0 || e !== 1'b1 || c !== 2'd3) begin
      tests_failed++; $display("[TB] FAIL overflow_outcome: got done=%b err=%b code=%0d, expected 0/1/3", d, e, c);
    end
    tests_run++;
    if (o_data_valid !== 1'b1 || o_data !== frame_q[2]) begin
      tests_failed++; $display("[TB] FAIL overflow_head: got dv=%b data=%h, expected 1/%h", o_data_valid, o_data, frame_q[2]);
    end
    drain();
    tests_run++;
    if (queues_differ() || done_cnt != done0) begin
      tests_failed++; $display("[TB] FAIL overflow_kept: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_full_push_pop();
    begin_test();
    i_data_ready = 1'b0;
    frame_q = {8'hA0, 8'h05};
    for (int i = 0; i < 5; i++) frame_q.push_back(8'($urandom));
    frame_q.push_back(frame_xor(7));
    model_payload(256);
    for (int i = 0; i < 6; i++) send_byte(frame_q[i]);
    // FIFO now full; the last payload byte arrives in the same cycle as a pop.
    i_data_ready = 1'b1;
    send_byte(frame_q[6]);
    send_byte(frame_q[7]);
    tests_run++;
    if (o_frame_done !== 1'b1 || o_frame_error !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL full_pushpop_done: got done=%b err=%b, expected 1/0", o_frame_done, o_frame_error);
    end
    drain();
    tests_run++;
    if (queues_differ()) begin
      tests_failed++; $display("[TB] FAIL full_pushpop_data: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_abort();
    logic d, e, v; logic [1:0] c; int done0, err0;
    begin_test();
    done0 = done_cnt; err0 = err_cnt;
    send_byte(8'h60); send_byte(8'h03); send_byte(8'h01);
    exp_q = {8'h01};
    i_enable = 1'b0; i_rx_busy = 1'b1;
    step(); step(); step();
    tests_run++;
    if (o_cmd_valid !== 1'b1 || o_rx_enable !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL abort_busy_hold: got cv=%b rxen=%b, expected 1/0", o_cmd_valid, o_rx_enable);
    end
    i_rx_busy = 1'b0;
    step();
    tests_run++;
    if (o_cmd_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL abort_idle: got cv=%b, expected 0", o_cmd_valid);
    end
    step();
    tests_run++;
    if (done_cnt != done0 || err_cnt != err0) begin
      tests_failed++; $display("[TB] FAIL abort_silent: got %0d done, %0d err pulses, expected 0/0",
                               done_cnt - done0, err_cnt - err0);
    end
    i_enable = 1'b1;
    frame_q = {8'h70, 8'h00, 8'h70};
    send_frame(1, d, e, c, v);
    tests_run++;
    if (d !== 1'b1 || e !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL abort_recover: got done=%b err=%b, expected 1/0", d, e);
    end
    drain();
    tests_run++;
    if (queues_differ()) begin
      tests_failed++; $display("[TB] FAIL abort_payload: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic d, e, v; logic [1:0] c;
    begin_test();
    frame_q = {8'h90, 8'h01, 8'h05, 8'h00};
    send_frame(0, d, e, c, v);
    tests_run++;
    if (e !== 1'b1 || c !== 2'd1) begin
      tests_failed++; $display("[TB] FAIL pre_reset_err: got err=%b code=%0d, expected 1/1", e, c);
    end
    drain();
    i_data_ready = 1'b0;
    send_byte(8'h80); send_byte(8'h02); send_byte(8'h12);
    reset = 1'b1;
    step();
    tests_run++;
    if ({o_cmd, o_cmd_valid, o_data, o_data_valid, o_frame_done, o_frame_error, o_err_code, o_rx_enable} !== 22'd0) begin
      tests_failed++;
      $display("[TB] FAIL midframe_reset: got cmd=%h cv=%b data=%h dv=%b done=%b err=%b code=%0d rxen=%b, expected all 0",
               o_cmd, o_cmd_valid, o_data, o_data_valid, o_frame_done, o_frame_error, o_err_code, o_rx_enable);
    end
    reset = 1'b0;
    step();
    frame_q = {8'h33, 8'h00, 8'h33};
    send_frame(0, d, e, c, v);
    tests_run++;
    if (d !== 1'b1 || o_cmd !== 8'h33) begin
      tests_failed++; $display("[TB] FAIL post_reset_frame: got done=%b cmd=%h, expected 1/33", d, o_cmd);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_zero_length();
    test_random_frames();
    test_timeout();
    test_overflow();
    test_full_push_pop();
    test_abort();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
